// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: word widths, NOP encoding, FSM states.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package inst_fetch_ctrl_pkg;

  // Width of architectural register values (miss counter, default instruction word).
  localparam int REG_VALUE_W = 16;

  // Instruction word presented while the fetch stage has nothing valid to hand on.
  localparam logic [REG_VALUE_W-1:0] NOP_WORD_DEF = 16'h0800;

  // Fetch FSM encodings.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [REG_VALUE_W-1:0] sat_inc(input logic [REG_VALUE_W-1:0] v);
    return (v == {REG_VALUE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Read-request bus between the fetch controller and the RAM arbiter.
// Latency: n/a; ram_rdata is valid in the same cycle ram_ack pulses.
// Backpressure: requester holds ram_req/ram_addr stable until ram_ack.
interface inst_fetch_ctrl_if
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = REG_VALUE_W
);
  logic              ram_req;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ack;
  logic [DATA_W-1:0] ram_rdata;

  modport master (output ram_req, ram_addr, input ram_ack, ram_rdata);
  modport slave  (input ram_req, ram_addr, output ram_ack, ram_rdata);
endinterface

// File: rtl/inst_fetch_ctrl_line_store.sv
// Direct-mapped instruction line store: valid/tag/data arrays, one write port, one lookup port.
// Latency: lookup is combinational; writes and flush take effect at the next rising edge.
// Backpressure: none; a flush in the same cycle as a write wins and nothing is stored.
module inst_line_store #(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 2,
  parameter int TAG_W  = 14,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data
);
  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // Valid bits: cleared by reset or flush, set by a fill of one entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data payload is only meaningful behind a valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: direct-mapped buffer lookup, miss refill from RAM, flush handling.
// Latency: hit is same-cycle; a miss costs 2 cycles plus RAM wait cycles before the word appears.
// Backpressure: stall_req freezes PC and IF/ID while inst_valid is low; RAM request held until ack.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter int               DATA_W   = 16,
  parameter int               DEPTH    = 4,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      pc_addr,
  input  logic                   flush,
  output logic [DATA_W-1:0]      inst_out,
  output logic                   inst_valid,
  output logic                   stall_req,
  inst_fetch_ctrl_if.master      ram,
  output logic [REG_VALUE_W-1:0] miss_cnt
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W;

  fetch_state_t      state;
  logic              ram_req_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              fill_en;

  // A fill only lands when the outstanding request is acked and no flush races it.
  assign fill_en = (state == REQ) && ram.ram_ack && !flush;

  inst_line_store #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_line_store (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (fill_en),
    .wr_idx  (ram_addr_q[IDX_W-1:0]),
    .wr_tag  (ram_addr_q[ADDR_W-1:IDX_W]),
    .wr_data (ram.ram_rdata),
    .rd_idx  (pc_addr[IDX_W-1:0]),
    .rd_tag  (pc_addr[ADDR_W-1:IDX_W]),
    .rd_hit  (rd_hit),
    .rd_data (rd_data)
  );

  assign hit        = rd_hit && !flush;
  assign inst_valid = hit;
  assign inst_out   = hit ? rd_data : NOP_WORD;
  assign stall_req  = !hit;

  assign ram.ram_req  = ram_req_q;
  assign ram.ram_addr = ram_addr_q;

  // Miss FSM: launch a refill, wait for the ack, and discard the reply if a flush intervened.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ram_req_q  <= 1'b0;
      ram_addr_q <= '0;
      miss_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit && !flush) begin
            state      <= REQ;
            ram_req_q  <= 1'b1;
            ram_addr_q <= pc_addr;
            miss_cnt   <= sat_inc(miss_cnt);
          end
        end
        REQ: begin
          if (ram.ram_ack) begin
            state      <= IDLE;
            ram_req_q  <= 1'b0;
            ram_addr_q <= '0;
          end else if (flush) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (ram.ram_ack) begin
            state      <= IDLE;
            ram_req_q  <= 1'b0;
            ram_addr_q <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          ram_req_q  <= 1'b0;
          ram_addr_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a request/data scoreboard.
// Latency: n/a.
// Backpressure: RAM side modelled with programmable ack delay.
module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk;
  logic        rst;
  logic [15:0] pc_addr;
  logic        flush;
  logic [15:0] inst_out;
  logic        inst_valid;
  logic        stall_req;
  logic [15:0] miss_cnt;

  int tests  = 0;
  int failed = 0;

  logic [15:0] exp_req_q[$];
  logic [15:0] exp_dat_q[$];

  inst_fetch_ctrl_if #(.ADDR_W(16), .DATA_W(16)) ram_bus ();

  inst_fetch_ctrl #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .DEPTH    (4),
    .NOP_WORD (16'h0800)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_addr    (pc_addr),
    .flush      (flush),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .stall_req  (stall_req),
    .ram        (ram_bus),
    .miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample each cycle until ram_req rises or the budget runs out.
  task automatic wait_req(output int stalls);
    int cyc;
    cyc    = 0;
    stalls = 0;
    while (ram_bus.ram_req !== 1'b1 && cyc < 20) begin
      if (stall_req) stalls++;
      @(negedge clk); #1;
      cyc++;
    end
    chk("req_seen", 32'(ram_bus.ram_req), 32'd1);
  endtask

  // Caller is at a falling edge. Presents a missing address, answers the request after
  // dly extra cycles, then checks the refilled word appears and the miss count.
  task automatic miss_fill(input logic [15:0] a, input logic [15:0] d, input int dly,
                           input logic [15:0] exp_cnt, input int exp_stall);
    int          stalls;
    logic [15:0] ea;
    logic [15:0] ed;
    pc_addr = a;
    #1;
    chk("miss_nop", 32'(inst_out), 32'(NOP));
    chk("miss_valid", 32'(inst_valid), 32'd0);
    exp_req_q.push_back(a);
    wait_req(stalls);
    ea = exp_req_q.pop_front();
    if (ram_bus.ram_req === 1'b1) begin
      chk("ram_addr", 32'(ram_bus.ram_addr), 32'(ea));
      repeat (dly) begin
        if (stall_req) stalls++;
        @(negedge clk); #1;
        chk("req_hold", 32'(ram_bus.ram_req), 32'd1);
        chk("addr_hold", 32'(ram_bus.ram_addr), 32'(ea));
      end
      if (stall_req) stalls++;
      ram_bus.ram_ack   = 1'b1;
      ram_bus.ram_rdata = d;
      exp_dat_q.push_back(d);
      @(negedge clk);
      ram_bus.ram_ack   = 1'b0;
      ram_bus.ram_rdata = 16'h0000;
      #1;
      ed = exp_dat_q.pop_front();
      chk("fill_valid", 32'(inst_valid), 32'd1);
      chk("fill_data", 32'(inst_out), 32'(ed));
      chk("fill_req_off", 32'(ram_bus.ram_req), 32'd0);
      chk("fill_cnt", 32'(miss_cnt), 32'(exp_cnt));
      if (exp_stall > 0) chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    end
  endtask

  task automatic hit_chk(input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp_cnt);
    @(negedge clk);
    pc_addr = a;
    #1;
    chk("hit_valid", 32'(inst_valid), 32'd1);
    chk("hit_data", 32'(inst_out), 32'(d));
    chk("hit_stall", 32'(stall_req), 32'd0);
    @(negedge clk); #1;
    chk("hit_no_req", 32'(ram_bus.ram_req), 32'd0);
    chk("hit_cnt", 32'(miss_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int s;
    rst               = 1'b0;
    pc_addr           = 16'h0010;
    flush             = 1'b0;
    ram_bus.ram_ack   = 1'b0;
    ram_bus.ram_rdata = 16'h0000;
    #1;
    chk("rst_req", 32'(ram_bus.ram_req), 32'd0);
    chk("rst_addr", 32'(ram_bus.ram_addr), 32'd0);
    chk("rst_out", 32'(inst_out), 32'(NOP));
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd1);
    chk("rst_cnt", 32'(miss_cnt), 32'd0);
    repeat (3) @(negedge clk);

    // First fetch after reset, ack on the second request cycle.
    rst = 1'b1;
    miss_fill(16'h0010, 16'h1234, 1, 16'd1, 3);
    hit_chk(16'h0010, 16'h1234, 16'd1);

    // Stray ack while idle and hitting is ignored.
    @(negedge clk);
    ram_bus.ram_ack   = 1'b1;
    ram_bus.ram_rdata = 16'hDEAD;
    @(negedge clk);
    ram_bus.ram_ack = 1'b0;
    #1;
    chk("idle_ack_out", 32'(inst_out), 32'h1234);
    chk("idle_ack_req", 32'(ram_bus.ram_req), 32'd0);

    // Same index, different tag, then back again.
    @(negedge clk); miss_fill(16'h0014, 16'h5678, 0, 16'd2, 0);
    @(negedge clk); miss_fill(16'h0010, 16'h1234, 0, 16'd3, 0);

    // Replacing index 0 leaves index 1 intact.
    @(negedge clk); miss_fill(16'h0011, 16'hAAAA, 2, 16'd4, 0);
    @(negedge clk); miss_fill(16'h0014, 16'h5678, 0, 16'd5, 0);
    hit_chk(16'h0011, 16'hAAAA, 16'd5);

    // Flush in idle: no hit, no miss launched that cycle, entries cleared.
    @(negedge clk);
    pc_addr = 16'h0011;
    flush   = 1'b1;
    #1;
    chk("flush_idle_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_idle_req", 32'(ram_bus.ram_req), 32'd0);
    chk("flush_idle_cnt", 32'(miss_cnt), 32'd5);
    @(negedge clk); miss_fill(16'h0011, 16'hAAAA, 0, 16'd6, 0);
    @(negedge clk); miss_fill(16'h0014, 16'h5678, 0, 16'd7, 0);

    // Flush during REQ moves to DROP; the late reply is discarded.
    @(negedge clk);
    pc_addr = 16'h0020;
    #1;
    wait_req(s);
    chk("drop_addr0", 32'(ram_bus.ram_addr), 32'h0020);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("drop_req", 32'(ram_bus.ram_req), 32'd1);
    chk("drop_addr", 32'(ram_bus.ram_addr), 32'h0020);
    ram_bus.ram_ack   = 1'b1;
    ram_bus.ram_rdata = 16'hBEEF;
    @(negedge clk);
    ram_bus.ram_ack = 1'b0;
    #1;
    chk("drop_idle_req", 32'(ram_bus.ram_req), 32'd0);
    chk("drop_not_stored", 32'(inst_out), 32'(NOP));
    chk("drop_cnt", 32'(miss_cnt), 32'd8);
    @(negedge clk); #1;
    chk("drop_rereq", 32'(ram_bus.ram_req), 32'd1);
    chk("drop_rereq_addr", 32'(ram_bus.ram_addr), 32'h0020);
    @(negedge clk); miss_fill(16'h0020, 16'h2222, 0, 16'd9, 0);
    @(negedge clk); miss_fill(16'h0011, 16'hAAAA, 0, 16'd10, 0);

    // Flush and ack together: flush wins, nothing stored.
    @(negedge clk);
    pc_addr = 16'h0030;
    #1;
    wait_req(s);
    chk("race_cnt", 32'(miss_cnt), 32'd11);
    flush             = 1'b1;
    ram_bus.ram_ack   = 1'b1;
    ram_bus.ram_rdata = 16'hDEAD;
    @(negedge clk);
    flush           = 1'b0;
    ram_bus.ram_ack = 1'b0;
    #1;
    chk("race_idle_req", 32'(ram_bus.ram_req), 32'd0);
    chk("race_no_write", 32'(inst_valid), 32'd0);
    @(negedge clk); #1;
    chk("race_rereq", 32'(ram_bus.ram_req), 32'd1);
    @(negedge clk); miss_fill(16'h0030, 16'h3333, 0, 16'd12, 0);

    // Asynchronous reset in the middle of a request.
    @(negedge clk);
    pc_addr = 16'h0040;
    #1;
    wait_req(s);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(ram_bus.ram_req), 32'd0);
    chk("arst_addr", 32'(ram_bus.ram_addr), 32'd0);
    chk("arst_cnt", 32'(miss_cnt), 32'd0);
    chk("arst_stall", 32'(stall_req), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    miss_fill(16'h0030, 16'h4444, 1, 16'd1, 3);
    @(negedge clk); miss_fill(16'h0011, 16'h5555, 0, 16'd2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
